// File: rtl/mdu_ctl.sv
// EXE-stage multiply/divide sequencer: iterative shift-add multiply and restoring
// divide over WIDTH cycles, plus the architectural HI/LO registers.
module mdu_ctl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic             hi_rd,
  input  logic             lo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand, dvd_raw;
  logic             neg_res, neg_rem, div_zero;

  logic             signed_op, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // MULT (00) and DIV (10) are the signed ops; iterations run on magnitudes.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & Reg1[WIDTH-1];
  assign b_neg     = signed_op & Reg2[WIDTH-1];
  assign a_mag     = a_neg ? -Reg1 : Reg1;
  assign b_mag     = b_neg ? -Reg2 : Reg2;

  assign last_iter = (count == CW'(WIDTH - 1));

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, mcand});
  // When rem_ge holds the true difference is below mcand, so WIDTH bits suffice.
  assign rem_diff = rem_sh[WIDTH-1:0] - mcand;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hi_rd | lo_rd | hi_we | lo_we);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      op_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      dvd_raw  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            mcand    <= op[1] ? b_mag : a_mag;
            dvd_raw  <= Reg1;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (Reg2 == '0);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (op_q[1]) begin
            acc_hi <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (op_q[1]) begin
            // Divide by zero bypasses sign correction: all-ones quotient, raw dividend.
            if (div_zero) begin
              lo <= '1;
              hi <= dvd_raw;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
